cram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares one single-port cram instance between requesters, e.g. CPU data path (port 0) and a loader/debug port (port 1).
- Accepts read/write commands with a req/gnt handshake and drives the cram address, data, we and oe lines.
- Returns read data plus a one-cycle completion pulse to the winning requester.
- Sits between the requesters and the cram; it is the only driver of the cram control inputs.

---
 rtl/cram_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/cram_arbiter.sv | 159 +++++++++++++++
 tb/tb_cram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_pkg.sv
// rtl/cram_pkg.sv - shared constants and helpers for the cram arbiter slice
package cram_pkg;

  // Sequencer states: one idle cycle to arbitrate, one cycle to drive the cram
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Requester identifiers, also used as the last_grant encoding
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default geometry of the cram instance this block fronts
  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_ADDRESS_WIDTH = 10;

  // The port that did not receive the previous grant
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way winner select with round-robin or fixed priority
module rr_arb2
  import cram_pkg::*;
#(
  parameter int p_fixed_priority = 0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  // Lone requester always wins; ties go to port 0 or to the port not served last
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = PORT0;
    if (req0_i && req1_i) begin
      if (p_fixed_priority != 0) begin
        winner_o = PORT0;
      end else begin
        winner_o = other_port(last_grant_i);
      end
    end else if (req1_i) begin
      winner_o = PORT1;
    end
  end

endmodule

// File: rtl/cram_arbiter.sv
// rtl/cram_arbiter.sv - two-requester arbiter and sequencer for a single-port cram
module cram_arbiter
  import cram_pkg::*;
#(
  parameter int p_data_width     = DEF_DATA_WIDTH,
  parameter int p_address_width  = DEF_ADDRESS_WIDTH,
  parameter int p_fixed_priority = 0
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_req0,
  input  logic                       i_w_req1,
  input  logic                       i_w_wr0,
  input  logic                       i_w_wr1,
  input  logic [p_address_width-1:0] i_w_addr0,
  input  logic [p_address_width-1:0] i_w_addr1,
  input  logic [p_data_width-1:0]    i_w_wdata0,
  input  logic [p_data_width-1:0]    i_w_wdata1,
  output logic                       o_r_gnt0,
  output logic                       o_r_gnt1,
  output logic                       o_r_done0,
  output logic                       o_r_done1,
  output logic [p_data_width-1:0]    o_r_rdata0,
  output logic [p_data_width-1:0]    o_r_rdata1,
  output logic                       o_w_busy,
  output logic [p_address_width-1:0] o_w_cram_address,
  output logic [p_data_width-1:0]    o_w_cram_in,
  output logic                       o_w_cram_we,
  output logic                       o_w_cram_oe,
  input  logic [p_data_width-1:0]    i_w_cram_out
);

  state_e                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       gnt0_q, gnt0_d;
  logic                       gnt1_q, gnt1_d;
  logic                       done0_q, done0_d;
  logic                       done1_q, done1_d;
  logic [p_data_width-1:0]    rdata0_q, rdata0_d;
  logic [p_data_width-1:0]    rdata1_q, rdata1_d;
  logic                       cmd_id_q, cmd_id_d;
  logic                       cmd_wr_q, cmd_wr_d;
  logic [p_address_width-1:0] cmd_addr_q, cmd_addr_d;
  logic [p_data_width-1:0]    cmd_wdata_q, cmd_wdata_d;

  logic arb_valid;
  logic arb_winner;

  rr_arb2 #(
    .p_fixed_priority(p_fixed_priority)
  ) u_rr_arb2 (
    .req0_i      (i_w_req0),
    .req1_i      (i_w_req1),
    .last_grant_i(last_grant_q),
    .valid_o     (arb_valid),
    .winner_o    (arb_winner)
  );

  // State and latched command registers; last_grant starts at port 1 so port 0 wins the first tie
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      cmd_id_q     <= PORT0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      cmd_id_q     <= cmd_id_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  // Next-state: accept a command in IDLE, complete it in ACCESS; gnt/done are single-cycle pulses
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cmd_id_d     = cmd_id_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          cmd_id_d     = arb_winner;
          cmd_wr_d     = (arb_winner == PORT1) ? i_w_wr1    : i_w_wr0;
          cmd_addr_d   = (arb_winner == PORT1) ? i_w_addr1  : i_w_addr0;
          cmd_wdata_d  = (arb_winner == PORT1) ? i_w_wdata1 : i_w_wdata0;
          gnt0_d       = (arb_winner == PORT0);
          gnt1_d       = (arb_winner == PORT1);
          last_grant_d = arb_winner;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        done0_d = (cmd_id_q == PORT0);
        done1_d = (cmd_id_q == PORT1);
        if (!cmd_wr_q) begin
          if (cmd_id_q == PORT0) begin
            rdata0_d = i_w_cram_out;
          end else begin
            rdata1_d = i_w_cram_out;
          end
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cram drive is decoded from state so reset drops we/oe immediately, before the write negedge
  always_comb begin
    o_w_busy         = (state_q == ST_ACCESS);
    o_w_cram_address = '0;
    o_w_cram_in      = '0;
    o_w_cram_we      = 1'b0;
    o_w_cram_oe      = 1'b0;
    if (state_q == ST_ACCESS) begin
      o_w_cram_address = cmd_addr_q;
      o_w_cram_we      = cmd_wr_q;
      o_w_cram_oe      = ~cmd_wr_q;
      if (cmd_wr_q) begin
        o_w_cram_in = cmd_wdata_q;
      end
    end
  end

  assign o_r_gnt0   = gnt0_q;
  assign o_r_gnt1   = gnt1_q;
  assign o_r_done0  = done0_q;
  assign o_r_done1  = done1_q;
  assign o_r_rdata0 = rdata0_q;
  assign o_r_rdata1 = rdata1_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// tb/tb_cram_arbiter.sv - self-checking bench for cram_arbiter with a cram model and scoreboard
module tb_cram_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct packed {
    logic          port;
    logic          rd;
    logic [DW-1:0] data;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_in, c_out;
  logic          c_we, c_oe;

  logic          fp_req0, fp_req1;
  logic          fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_busy, fp_we, fp_oe;
  logic [DW-1:0] fp_rdata0, fp_rdata1, fp_in;
  logic [AW-1:0] fp_addr;

  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] shadow [0:1023];

  logic  gq[$];
  done_t dq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  always #5 clk = ~clk;

  cram_arbiter #(.p_data_width(DW), .p_address_width(AW), .p_fixed_priority(0)) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n),
    .i_w_req0(req0), .i_w_req1(req1), .i_w_wr0(wr0), .i_w_wr1(wr1),
    .i_w_addr0(addr0), .i_w_addr1(addr1), .i_w_wdata0(wdata0), .i_w_wdata1(wdata1),
    .o_r_gnt0(gnt0), .o_r_gnt1(gnt1), .o_r_done0(done0), .o_r_done1(done1),
    .o_r_rdata0(rdata0), .o_r_rdata1(rdata1), .o_w_busy(busy),
    .o_w_cram_address(c_addr), .o_w_cram_in(c_in), .o_w_cram_we(c_we), .o_w_cram_oe(c_oe),
    .i_w_cram_out(c_out)
  );

  cram_arbiter #(.p_data_width(DW), .p_address_width(AW), .p_fixed_priority(1)) dut_fp (
    .i_w_clk(clk), .i_w_rst_n(rst_n),
    .i_w_req0(fp_req0), .i_w_req1(fp_req1), .i_w_wr0(1'b0), .i_w_wr1(1'b0),
    .i_w_addr0(10'h001), .i_w_addr1(10'h002), .i_w_wdata0(16'h0000), .i_w_wdata1(16'h0000),
    .o_r_gnt0(fp_gnt0), .o_r_gnt1(fp_gnt1), .o_r_done0(fp_done0), .o_r_done1(fp_done1),
    .o_r_rdata0(fp_rdata0), .o_r_rdata1(fp_rdata1), .o_w_busy(fp_busy),
    .o_w_cram_address(fp_addr), .o_w_cram_in(fp_in), .o_w_cram_we(fp_we), .o_w_cram_oe(fp_oe),
    .i_w_cram_out(16'h5A5A)
  );

  // Cram model: write on the falling edge, asynchronous read
  always @(negedge clk) begin
    if (c_we) mem[c_addr] <= c_in;
  end
  assign c_out = mem[c_addr];

  // Scoreboard sampling, done at the falling edge inside tick
  task automatic sample();
    logic  g;
    done_t d;
    if (rst_n !== 1'b1) begin
      exp_rd0 = '0;
      exp_rd1 = '0;
      return;
    end
    n_checks++;
    if (c_we && c_oe) begin
      n_fail++; $display("FAIL we_oe_exclusive: we=%b oe=%b required not both 1", c_we, c_oe);
    end
    n_checks++;
    if (gnt0 && gnt1) begin
      n_fail++; $display("FAIL gnt_onehot: gnt0=%b gnt1=%b required at most one", gnt0, gnt1);
    end
    if (gnt0 || gnt1) begin
      n_checks++;
      if (gq.size() == 0) begin
        n_fail++; $display("FAIL unexpected_gnt: gnt0=%b gnt1=%b required none", gnt0, gnt1);
      end else begin
        g = gq.pop_front();
        if (gnt1 !== g) begin
          n_fail++; $display("FAIL grant_order: granted port %0d required port %0d", gnt1, g);
        end
      end
    end
    if (done0 || done1) begin
      n_checks++;
      if (dq.size() == 0) begin
        n_fail++; $display("FAIL unexpected_done: done0=%b done1=%b required none", done0, done1);
      end else begin
        d = dq.pop_front();
        if (done1 !== d.port || (done0 && done1)) begin
          n_fail++; $display("FAIL done_port: done0=%b done1=%b required port %0d", done0, done1, d.port);
        end
        if (d.rd && d.port) exp_rd1 = d.data;
        if (d.rd && !d.port) exp_rd0 = d.data;
        n_checks++;
        if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
          n_fail++;
          $display("FAIL rdata: rdata0=%h rdata1=%h required %h %h", rdata0, rdata1, exp_rd0, exp_rd1);
        end
      end
    end
  endtask

  // One clock: sample at negedge, return just after the next posedge
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat);
    done_t d;
    d.port = p;
    d.rd   = !w;
    d.data = w ? '0 : shadow[a];
    gq.push_back(p);
    dq.push_back(d);
    if (w) shadow[a] = dat;
  endtask

  task automatic drive(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat);
    if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = dat; end
    else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = dat; end
  endtask

  // Single access from one port with latency checks on gnt and done
  task automatic access(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat);
    int   waited;
    logic got;
    push_exp(p, w, a, dat);
    drive(p, w, a, dat);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 10) begin
      tick();
      waited++;
      got = p ? gnt1 : gnt0;
    end
    n_checks++;
    if (!got || waited != 1) begin
      n_fail++; $display("FAIL gnt_latency: port %0d gnt after %0d cycles (seen=%b) required 1", p, waited, got);
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
    tick();
    n_checks++;
    if ((p ? done1 : done0) !== 1'b1) begin
      n_fail++; $display("FAIL done_latency: port %0d done=%b required 1 one cycle after gnt", p, p ? done1 : done0);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({gnt0, gnt1, done0, done1, c_we, c_oe, busy} !== 7'b0 || c_addr !== '0 || c_in !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/done/we/oe/busy=%b addr=%h in=%h required all 0",
               {gnt0, gnt1, done0, done1, c_we, c_oe, busy}, c_addr, c_in);
    end
    n_checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++; $display("FAIL reset_rdata: rdata0=%h rdata1=%h required 0000 0000", rdata0, rdata1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({gnt0, gnt1, done0, done1, c_we, c_oe, busy} !== 7'b0) begin
        n_fail++; $display("FAIL idle_outputs: cycle %0d gnt/done/we/oe/busy=%b required 0", i, {gnt0, gnt1, done0, done1, c_we, c_oe, busy});
      end
    end
  endtask

  task automatic test_single_port();
    access(1'b0, 1'b1, 10'h005, 16'hBEEF);
    access(1'b0, 1'b0, 10'h005, 16'h0000);
    n_checks++;
    if (rdata0 !== 16'hBEEF || rdata1 !== 16'h0000) begin
      n_fail++; $display("FAIL single_read: rdata0=%h rdata1=%h required beef 0000", rdata0, rdata1);
    end
  endtask

  task automatic test_wrap_address();
    access(1'b0, 1'b1, 10'h000, 16'h0F0F);
    access(1'b1, 1'b1, 10'h3FF, 16'h1234);
    access(1'b1, 1'b0, 10'h3FF, 16'h0000);
    n_checks++;
    if (rdata1 !== 16'h1234) begin
      n_fail++; $display("FAIL wrap_read: rdata1=%h required 1234", rdata1);
    end
    access(1'b1, 1'b0, 10'h000, 16'h0000);
    n_checks++;
    if (rdata1 !== 16'h0F0F) begin
      n_fail++; $display("FAIL addr0_intact: rdata1=%h required 0f0f", rdata1);
    end
  endtask

  // Both ports raise a read together; first is the port expected to win the tie
  task automatic tie_reads(input logic first);
    logic g0, g1;
    push_exp(first, 1'b0, first ? 10'h3FF : 10'h005, '0);
    push_exp(!first, 1'b0, first ? 10'h005 : 10'h3FF, '0);
    drive(1'b0, 1'b0, 10'h005, '0);
    drive(1'b1, 1'b0, 10'h3FF, '0);
    g0 = 1'b0;
    g1 = 1'b0;
    for (int i = 0; i < 12 && !(g0 && g1); i++) begin
      tick();
      if (gnt0) begin g0 = 1'b1; req0 = 1'b0; end
      if (gnt1) begin g1 = 1'b1; req1 = 1'b0; end
    end
    n_checks++;
    if (!(g0 && g1)) begin
      n_fail++; $display("FAIL tie_timeout: granted0=%b granted1=%b required both", g0, g1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_round_robin_tie();
    tie_reads(1'b0);
    access(1'b0, 1'b0, 10'h005, '0);
    tie_reads(1'b1);
  endtask

  task automatic test_back_to_back();
    int   grants;
    logic prev_busy;
    for (int i = 0; i < 8; i++) begin
      push_exp((i % 2) == 0, 1'b0, ((i % 2) == 0) ? 10'h3FF : 10'h005, '0);
    end
    drive(1'b0, 1'b0, 10'h005, '0);
    drive(1'b1, 1'b0, 10'h3FF, '0);
    grants    = 0;
    prev_busy = busy;
    for (int i = 0; i < 40 && grants < 8; i++) begin
      tick();
      n_checks++;
      if (busy !== ~prev_busy) begin
        n_fail++; $display("FAIL busy_toggle: cycle %0d busy=%b required %b", i, busy, ~prev_busy);
      end
      prev_busy = busy;
      if (gnt0 || gnt1) grants++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_checks++;
    if (grants != 8) begin
      n_fail++; $display("FAIL b2b_grants: grants=%0d required 8", grants);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_fixed_priority();
    int g0cnt;
    g0cnt   = 0;
    fp_req0 = 1'b1;
    fp_req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fp_gnt0) g0cnt++;
      n_checks++;
      if (fp_gnt1 !== 1'b0) begin
        n_fail++; $display("FAIL fp_gnt1: cycle %0d gnt1=%b required 0", i, fp_gnt1);
      end
    end
    fp_req0 = 1'b0;
    fp_req1 = 1'b0;
    tick();
    tick();
    n_checks++;
    if (g0cnt != 6) begin
      n_fail++; $display("FAIL fp_gnt0_count: gnt0 pulses=%0d required 6", g0cnt);
    end
    n_checks++;
    if (fp_rdata0 !== 16'h5A5A || fp_rdata1 !== 16'h0000) begin
      n_fail++; $display("FAIL fp_rdata: rdata0=%h rdata1=%h required 5a5a 0000", fp_rdata0, fp_rdata1);
    end
  endtask

  task automatic test_reset_during_access();
    access(1'b0, 1'b1, 10'h010, 16'h5555);
    drive(1'b0, 1'b1, 10'h010, 16'hAAAA);
    tick();
    n_checks++;
    if (gnt0 !== 1'b1 || c_we !== 1'b1 || c_addr !== 10'h010) begin
      n_fail++; $display("FAIL abort_setup: gnt0=%b we=%b addr=%h required 1 1 010", gnt0, c_we, c_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (c_we !== 1'b0 || c_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: we=%b oe=%b busy=%b required 0 0 0", c_we, c_oe, busy);
    end
    req0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b done0=%b required 0 0", busy, done0);
    end
    access(1'b0, 1'b0, 10'h010, '0);
    n_checks++;
    if (rdata0 !== 16'h5555) begin
      n_fail++; $display("FAIL abort_no_commit: rdata0=%h required 5555", rdata0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req0    = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0   = '0;   addr1 = '0;  wdata0 = '0; wdata1 = '0;
    fp_req0 = 1'b0; fp_req1 = 1'b0;
    test_reset();
    test_single_port();
    test_wrap_address();
    test_round_robin_tie();
    test_back_to_back();
    test_fixed_priority();
    test_reset_during_access();
    n_checks++;
    if (gq.size() != 0 || dq.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d grants %0d dones outstanding required 0 0", gq.size(), dq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
